// File: rtl/spi_slave_core.sv
// SPI responder (slave) with an MMIO register slot: RX data, TX buffer, ctrl, status.
// Latency: 3 clk from any SPI pin to its action (2-FF sync + edge register); register writes act on the next clk.
// Backpressure: none; an unread RX byte is overwritten by the next one and flagged in ovr.
//
// Ports: clk, reset (async, active low); cs/read/write/addr/wr_data/rd_data MMIO slot;
//        spi_sclk/spi_mosi/spi_ss_n from the master; spi_miso/spi_miso_oe back to it;
//        irq only when SPI_SLV_IRQ_EN is defined.
// rd_data = {20'b0, busy, ovr, tx_empty, rx_valid, rx_data}, independent of addr.
// Writes: addr 0 clears rx_valid/ovr, addr 1 loads tx_data, addr 2 loads ctrl {irq_en, cpha, cpol}.
module spi_slave_core #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso,
  output logic        spi_miso_oe
`ifdef SPI_SLV_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_nxt;

  logic sclk_q1, sclk_q2, sclk_prev;
  logic mosi_q1, mosi_q2;
  logic ss_q1, ss_q2, ss_prev;

  logic          cpol, cpha;
  logic [W-1:0]  tx_data, tx_shift, rx_shift, rx_data;
  logic          tx_empty, rx_valid, ovr;
  logic [CW-1:0] bit_cnt;
  logic          byte_done;   // cpha=0: 8th sample seen, next trailing edge reloads
  logic          first_lead;  // cpha=1: first leading edge of a byte does not shift

  // Reads carry no side effects, so read strobe and upper address bits are not needed.
  logic unused_bits;
  assign unused_bits = ^{read, addr[4:2], wr_data[31:W]};

  wire wr_clr  = cs & write & (addr[1:0] == 2'b00);
  wire wr_tx   = cs & write & (addr[1:0] == 2'b01);
  wire wr_ctrl = cs & write & (addr[1:0] == 2'b10);

  // Pin synchronizers plus previous-value registers for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {sclk_q1, sclk_q2, sclk_prev} <= 3'b000;
      {mosi_q1, mosi_q2}            <= 2'b00;
      {ss_q1, ss_q2, ss_prev}       <= 3'b111;
    end else begin
      sclk_q1   <= spi_sclk;
      sclk_q2   <= sclk_q1;
      sclk_prev <= sclk_q2;
      mosi_q1   <= spi_mosi;
      mosi_q2   <= mosi_q1;
      ss_q1     <= spi_ss_n;
      ss_q2     <= ss_q1;
      ss_prev   <= ss_q2;
    end
  end

  wire ss_fall = ss_prev & ~ss_q2;
  wire ss_rise = ~ss_prev & ss_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ss_fall) state_nxt = XFER;
      XFER: if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clock edges only count while staying selected; an edge coinciding with
  // deselection belongs to a discarded byte.
  wire enter  = (state == IDLE) && (state_nxt == XFER);
  wire active = (state == XFER) && (state_nxt == XFER);
  wire edge_d = sclk_q2 ^ sclk_prev;
  wire lead   = active & edge_d & (sclk_q2 != cpol);
  wire trail  = active & edge_d & (sclk_q2 == cpol);

  wire sample   = cpha ? trail : lead;
  wire last     = sample && (bit_cnt == LAST_BIT);
  wire reload   = enter || (cpha ? last : (trail & byte_done));
  wire do_shift = cpha ? (lead & ~first_lead) : (trail & ~byte_done);
  wire [W-1:0] rx_next = {rx_shift[W-2:0], mosi_q2};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      tx_data    <= '0;
      tx_shift   <= '1;
      tx_empty   <= 1'b1;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      ovr        <= 1'b0;
      bit_cnt    <= '0;
      byte_done  <= 1'b0;
      first_lead <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        cpol <= wr_data[0];
        cpha <= wr_data[1];
      end

      // Reload consumes the old buffer; a same-cycle CPU write refills it.
      if (reload)        tx_shift <= tx_empty ? '1 : tx_data;
      else if (do_shift) tx_shift <= {tx_shift[W-2:0], 1'b0};

      if (wr_tx) begin
        tx_data  <= wr_data[W-1:0];
        tx_empty <= 1'b0;
      end else if (reload) begin
        tx_empty <= 1'b1;
      end

      if (sample) rx_shift <= rx_next;

      // A completing byte beats a same-cycle clear and then does not flag overrun.
      if (last) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (wr_clr) begin
        rx_valid <= 1'b0;
      end

      if (last && rx_valid && !wr_clr) ovr <= 1'b1;
      else if (wr_clr)                 ovr <= 1'b0;

      if (!active)     bit_cnt <= '0;
      else if (sample) bit_cnt <= last ? '0 : bit_cnt + 1'b1;

      if (!active || reload) byte_done <= 1'b0;
      else if (last && !cpha) byte_done <= 1'b1;

      if (!active || reload) first_lead <= 1'b1;
      else if (lead)         first_lead <= 1'b0;
    end
  end

  wire busy = (state == XFER);

  assign spi_miso    = busy ? tx_shift[W-1] : 1'b1;
  assign spi_miso_oe = busy;
  assign rd_data     = {{(32-W-4){1'b0}}, busy, ovr, tx_empty, rx_valid, rx_data};

`ifdef SPI_SLV_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= wr_data[2];
      irq <= irq_en & (rx_valid | ovr);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a behavioural SPI master drives frames in all four modes
// while expected master-received data and register images queue in a scoreboard.
module tb_spi_slave_core;

  localparam int HP = 6;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        spi_sclk = 1'b0, spi_mosi = 1'b0, spi_ss_n = 1'b1;
  logic        spi_miso, spi_miso_oe;
`ifdef SPI_SLV_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  spi_slave_core dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
`ifdef SPI_SLV_IRQ_EN
    , .irq(irq)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic cpol_m = 1'b0, cpha_m = 1'b0;

  typedef struct {
    logic [15:0] miso;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       tx_load;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic set_mode(input logic cp, input logic ch);
    reg_wr(5'd2, {30'b0, ch, cp});
    cpol_m = cp;
    cpha_m = ch;
    @(negedge clk);
    spi_sclk = cp;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_low();
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic ss_high();
    @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  // Rest of a half period; with hit, a clear write lands on the clk edge that
  // acts on the sclk edge just driven (3 clk after the pin change).
  task automatic wait_half(input bit hit);
    if (hit) begin
      @(negedge clk);
      reg_wr(5'd0, 32'h0);
      repeat (HP - 4) @(negedge clk);
    end else begin
      repeat (HP - 1) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [15:0] mo, input int nbits, input int clr_bit,
                       output logic [15:0] mi);
    mi = '0;
    if (!cpha_m) spi_mosi = mo[nbits-1];
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (!cpha_m) mi[nbits-1-i] = spi_miso;
      else         spi_mosi = mo[nbits-1-i];
      spi_sclk = ~cpol_m;
      wait_half(!cpha_m && i == clr_bit);
      @(negedge clk);
      if (cpha_m)            mi[nbits-1-i] = spi_miso;
      else if (i + 1 < nbits) spi_mosi = mo[nbits-2-i];
      spi_sclk = cpol_m;
      wait_half(cpha_m && i == clr_bit);
    end
  endtask

  task automatic run_frame(input logic [15:0] mo, input int nbits, input int clr_bit,
                           input string nm);
    logic [15:0] mi;
    exp_t e;
    ss_low();
    frame(mo, nbits, clr_bit, mi);
    ss_high();
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      check({nm, "_miso"}, {16'h0, mi}, {16'h0, e.miso});
      check({nm, "_rd"}, rd_data, e.rd);
    end
  endtask

  logic [15:0] mi_part;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 32'h33C};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h96, 8'hC3, 8'h96, 32'h3C3};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h0F, 8'hF0, 8'h0F, 32'h3F0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h01, 8'h00, 32'h301};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 8'hFF, 32'h380};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rd", rd_data, 32'h200);
    check("rst_miso", {31'b0, spi_miso}, 32'd1);
    check("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    read = 1'b1; cs = 1'b1;
    @(negedge clk);
    check("rst_rd_after", rd_data, 32'h200);
    read = 1'b0; cs = 1'b0;

    // Single frames in every mode.
    for (int i = 0; i < 5; i++) begin
      set_mode(vecs[i].cpol, vecs[i].cpha);
      reg_wr(5'd0, 32'h0);
      if (vecs[i].tx_load) reg_wr(5'd1, {24'h0, vecs[i].tx});
      check($sformatf("v%0d_tx_empty", i), {31'b0, rd_data[9]}, {31'b0, ~vecs[i].tx_load});
      sb.push_back('{{8'h00, vecs[i].exp_miso}, vecs[i].exp_rd});
      run_frame({8'h00, vecs[i].mo}, 8, -1, $sformatf("v%0d", i));
    end

    // Mode 3, two back-to-back bytes with no TX data: overrun, then clear.
    set_mode(1'b1, 1'b1);
    reg_wr(5'd0, 32'h0);
    sb.push_back('{16'hFFFF, 32'h77E});
    run_frame(16'h817E, 16, -1, "m3_two");
    reg_wr(5'd0, 32'h0);
    check("m3_clr", rd_data, 32'h27E);

    // Mode 1, deselect after 5 bits: partial byte dropped.
    set_mode(1'b0, 1'b1);
    ss_low();
    frame(16'h0015, 5, -1, mi_part);
    check("part_oe_mid", {31'b0, spi_miso_oe}, 32'd1);
    check("part_busy_mid", {31'b0, rd_data[11]}, 32'd1);
    ss_high();
    check("part_rd", rd_data, 32'h27E);
    check("part_oe", {31'b0, spi_miso_oe}, 32'd0);
    check("part_miso", {31'b0, spi_miso}, 32'd1);
    reg_wr(5'd1, 32'h3A);
    sb.push_back('{16'h003A, 32'h355});
    run_frame(16'h0055, 8, -1, "m1_after_part");

    // Mode 0, clear lands on the same clk as the 8th sample (rx_valid already 1).
    set_mode(1'b0, 1'b0);
    sb.push_back('{16'h00FF, 32'h3C7});
    run_frame(16'h00C7, 8, 7, "clr_vs_sample");

    // Reset mid-frame, then a mode 2 frame.
    reg_wr(5'd1, 32'h11);
    ss_low();
    frame(16'h0005, 3, -1, mi_part);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_miso", {31'b0, spi_miso}, 32'd1);
    check("mid_rst_oe", {31'b0, spi_miso_oe}, 32'd0);
    check("mid_rst_rd", rd_data, 32'h200);
    @(negedge clk);
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    set_mode(1'b1, 1'b0);
    reg_wr(5'd1, 32'hC6);
    sb.push_back('{16'h00C6, 32'h339});
    run_frame(16'h0039, 8, -1, "m2_after_rst");

`ifdef SPI_SLV_IRQ_EN
    reg_wr(5'd0, 32'h0);
    set_mode(1'b0, 1'b0);
    reg_wr(5'd2, 32'h4);
    sb.push_back('{16'h00FF, 32'h342});
    run_frame(16'h0042, 8, -1, "irq_frame");
    check("irq_set", {31'b0, irq}, 32'd1);
    reg_wr(5'd0, 32'h0);
    @(negedge clk);
    check("irq_clr", {31'b0, irq}, 32'd0);
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Memory-mapped SPI responder (slave) for the MMIO bus, the counterpart of the team's SPI master core. It receives frames clocked by an external master on `spi_sclk`/`spi_mosi` under `spi_ss_n`, returns a CPU-loaded byte on `spi_miso`, and exposes RX data, TX buffer and status through the standard `cs`/`read`/`write`/`addr` slot interface. All SPI pins are oversampled in the `clk` domain.

## Interface
- `W`, 8, frame width in bits; MSB first.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `cs`, `read`, `write`  in  1 each  slot select and strobes.
- `addr`  in  5  register address; only `addr[1:0]` decoded.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  `{20'b0, busy, ovr, tx_empty, rx_valid, rx_data[7:0]}`; independent of `addr`.
- `spi_sclk`, `spi_mosi`, `spi_ss_n`  in  1 each  bus pins from master (asynchronous).
- `spi_miso`  out  1  serial data to master.
- `spi_miso_oe`  out  1  MISO output enable for top-level tri-state; 1 only while selected.
- `irq`  out  1  present only with `SPI_SLV_IRQ_EN`.

## Operation
- Registers (write, `cs & write`): `addr=00` any data clears `rx_valid` and `ovr`; `addr=01` loads `tx_data <= wr_data[7:0]`, `tx_empty <= 0`; `addr=10` loads ctrl: bit0 `cpol`, bit1 `cpha`, bit2 `irq_en`.
- Reads have no side effects.
- Pins pass through 2-FF synchronizers; edges detected on the synchronized `sclk` vs. its previous value. Leading edge = transition away from `cpol`; trailing = back to `cpol`.
- FSM: `IDLE` -> `XFER` on synchronized `ss_n` falling; `XFER` -> `IDLE` on `ss_n` rising (any bit position).
- Entering `XFER` (and at each byte boundary): `tx_shift <= tx_empty ? 8'hFF : tx_data`; `tx_empty <= 1`. `bit_cnt <= 0`.
- `spi_miso = tx_shift[7]` in `XFER`, 1 in `IDLE`; `spi_miso_oe = (state==XFER)`.
- `cpha=0`: sample `mosi` on leading edge; shift `tx_shift` left on trailing edge, except the trailing edge after the 8th sample performs the reload instead.
- `cpha=1`: shift on leading edge except the first leading edge of each byte; sample on trailing edge; reload at the 8th sample.
- 8th sample: `rx_data <= {rx_shift[6:0], mosi}`, `rx_valid <= 1`; if `rx_valid` was already 1, `ovr <= 1` (new data overwrites).
- `busy = (state==XFER)`.
- `ss_n` rise mid-byte: partial byte discarded, `rx_data`/`rx_valid` unchanged, `bit_cnt` cleared; a loaded-but-unsent TX byte is lost (`tx_empty` already 1).
- CPU write to `addr=01` during `XFER` updates `tx_data` only; it takes effect at the next reload.
- Same-cycle clear (`addr=00`) and 8th sample: the sample wins (`rx_valid=1`); `ovr` is not set.

## Timing
- Reset values: `spi_miso=1`, `spi_miso_oe=0`, `rd_data=32'h0000_0200` (`tx_empty=1`), `cpol=cpha=0`, `irq=0`, state `IDLE`.
- Pin-to-action latency: 3 `clk` (2 sync + edge register).
- `rx_valid` visible on `rd_data` 3 `clk` after the 8th sampling `sclk` edge at the pin.
- Supported `sclk` frequency ≤ `clk`/8; each `sclk` phase must be ≥ 4 `clk`.
- `ss_n` fall to first `sclk` edge ≥ 4 `clk`.
- Register writes take effect on the next `clk` edge.

## Configuration
- `SPI_SLV_IRQ_EN` defined: `irq` port exists; `irq = irq_en & (rx_valid | ovr)`, registered, cleared one cycle after the `addr=00` write.
- Undefined: no `irq` port; ctrl bit2 is ignored.

## Test plan
- Reset, then read -> `rd_data=0x200`, `spi_miso=1`, `spi_miso_oe=0`.
- Mode 0: write `tx_data=0xA5`; master sends `0x3C` -> master receives `0xA5`, `rd_data[8:0]=0x13C`, `tx_empty=1`.
- Mode 3 (`cpol=cpha=1`): master sends two bytes `0x81`, `0x7E` with no TX write -> master receives `0xFF`, `0xFF`; `rx_data=0x7E`, `ovr=1`; write `addr=00` -> `rx_valid=0`, `ovr=0`.
- Mode 1: `ss_n` raised after 5 bits -> `rx_valid` unchanged, `busy=0`; the next full frame `0x55` is received correctly.
- Assert `reset=0` mid-frame -> all outputs return to reset values immediately; after release, a full mode 2 frame exchanges correctly.
- With `SPI_SLV_IRQ_EN`, `irq_en=1`: frame `0x42` -> `irq=1` within 4 `clk` of the last edge; `irq` low after the clear.
